rx_dma_chan_ctrl: RTL and testbench
===================================

# rx_dma_chan_ctrl

Per-channel start/stop controller for the RX DMA Calypte datapath. Accepts start/stop commands from the MI register layer and tracks in-flight packets per channel as the header manager accepts them and the PCIe upstream writer completes them. Produces the channel-enable vector that gates packet acceptance. Reports a channel as stopped only after all of its accepted packets have drained.

## Interface

Reset is synchronous and active-high on `RESET`, sampled on the rising edge of `CLK`; the block uses one clock only.

Parameters:
- `CHANNELS`, 16: number of DMA channels, a power of two ≥ 2.
- `INFLIGHT_WIDTH`, 8: width of the per-channel in-flight packet counter.
- `TIMEOUT_CYCLES`, 1024: stop-drain timeout; used only with the macro.

Ports (CW = $clog2(CHANNELS)):
- `CLK`  in  1  — clock.
- `RESET`  in  1  — synchronous, active-high.
- `CMD_VLD`  in  1  — command valid.
- `CMD_CHAN`  in  CW  — command channel.
- `CMD_START`  in  1  — 1 = start, 0 = stop.
- `CMD_RDY`  out  1  — command accepted when `CMD_VLD & CMD_RDY`.
- `PKT_ACPT_VLD`  in  1  — one packet accepted for `PKT_ACPT_CHAN`.
- `PKT_ACPT_CHAN`  in  CW  — channel of the accepted packet.
- `PKT_DONE_VLD`  in  1  — one packet fully written for `PKT_DONE_CHAN`.
- `PKT_DONE_CHAN`  in  CW  — channel of the completed packet.
- `CHAN_EN`  out  CHANNELS  — bit set = channel may accept new packets.
- `CHAN_STATUS`  out  2*CHANNELS  — per-channel state code.
- `STOP_DONE`  out  CHANNELS  — one-cycle pulse per channel that has reached STOPPED on a stop command.
- `TIMEOUT_ERR`  out  CHANNELS  — sticky forced-stop flag.

## Operation

Each channel has a state:
- STOPPED = 00
- RUNNING = 01
- STOPPING = 10
- Code 11 never occurs.

Command handshake:
- `CMD_RDY` is combinational: it is 0 while `RESET` is high, 0 while the addressed channel is STOPPING, and 1 otherwise.
- Commands are never dropped. The source holds `CMD_VLD` and `CMD_CHAN` stable until accepted.

Transitions on an accepted command:
- STOPPED + start → RUNNING.
- RUNNING + stop → STOPPING.
- RUNNING + start is a no-op.
- STOPPED + stop: the state does not change, and `STOP_DONE[ch]` pulses in the next cycle so software always gets an acknowledgement.

Drain:
- In STOPPING, when the next value of the counter is 0, the state becomes STOPPED at the next edge and `STOP_DONE[ch]` is high for exactly that following cycle.

In-flight counter (per channel):
- next = cnt + ACPT − DONE, evaluated each cycle.
- ACPT and DONE for the same channel in the same cycle leave the counter unchanged.
- Accepts are counted in every state. Because `CHAN_EN` is registered, an accept in the cycle a stop command is taken is legal and counted.
- DONE when the counter is 0 is ignored; the counter holds at 0.
- ACPT when the counter is at all-ones is a protocol violation; the counter saturates at all-ones.

Outputs:
- `CHAN_EN[ch]` = (state == RUNNING), registered.
- `CHAN_STATUS` is the registered state code.
- Several channels may pulse `STOP_DONE` in the same cycle.

## Timing

Reset values: all channels STOPPED, counters 0, `CHAN_EN` 0, `CHAN_STATUS` 0, `STOP_DONE` 0, `TIMEOUT_ERR` 0, `CMD_RDY` 0. Reset asserted mid-operation discards all in-flight counts and does not pulse `STOP_DONE`.

Latencies:
- Command accepted in cycle N → `CHAN_EN` and `CHAN_STATUS` updated in cycle N+1.
- Minimum stop latency: stop accepted in N with counter 0 and no accept in N → STOPPING in N+1, STOPPED and `STOP_DONE` in N+2.
- Stop on a STOPPED channel in N → `STOP_DONE` in N+1.
- Last DONE in cycle M while STOPPING → STOPPED and `STOP_DONE` in M+1.
- `CMD_RDY` for a STOPPING channel rises in the same cycle its state reads STOPPED.

## Configuration

Macro `RX_DMA_CHAN_CTRL_TIMEOUT_EN`.

When defined:
- Each channel has a timer of width $clog2(TIMEOUT_CYCLES+1).
- The timer is cleared on entering STOPPING and increments each cycle spent in STOPPING.
- When the timer reaches `TIMEOUT_CYCLES` with a nonzero counter: the state is forced to STOPPED, the counter is cleared, `STOP_DONE[ch]` pulses, and `TIMEOUT_ERR[ch]` is set.
- `TIMEOUT_ERR[ch]` is cleared by an accepted start command on that channel.
- Late DONE events after a forced stop are ignored (the counter holds at 0).

When undefined: no timers are built, `TIMEOUT_ERR` is tied to 0, and STOPPING waits for drain indefinitely.

## Structure

Package `rx_dma_chan_ctrl_pkg` holds:
- The state enum typedef and the 2-bit code constants.
- The channel-index width function.

One sub-module, `rx_dma_chan_ctrl_fsm`, is instantiated per channel through a generate loop. It contains the state register, the in-flight counter, the optional timer and the `STOP_DONE` register. The top level does the following:
- Decodes `CMD_CHAN`, `PKT_ACPT_CHAN` and `PKT_DONE_CHAN` into one-hot vectors.
- Multiplexes the STOPPING indication for `CMD_RDY`.

## Test plan

- Reset, then start ch3 → `CHAN_EN` = 0x0008 one cycle after acceptance, `CHAN_STATUS[7:6]` = 01.
- ch3 RUNNING with 5 accepts, stop, then 5 DONEs spaced 3 cycles apart → STOPPING throughout. `CMD_RDY` is 0 for ch3 and 1 for ch4. STOPPED and `STOP_DONE[3]` pulse one cycle after the 5th DONE.
- Stop accepted with ACPT ch3 in the same cycle, counter 0 → counter becomes 1 and the state stays STOPPING until one DONE arrives.
- Simultaneous ACPT and DONE on ch0 with counter 2 → counter stays 2. DONE on ch1 with counter 0 → counter stays 0 and there is no state effect.
- Stop on STOPPED ch7 → `STOP_DONE[7]` pulses next cycle. Drain completion on ch2 in the same cycle → `STOP_DONE` = 0x0084.
- With `RX_DMA_CHAN_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: stop ch5 with 1 in-flight packet and no DONE → forced STOPPED after 16 cycles and `TIMEOUT_ERR[5]` = 1. A start on ch5 clears it. Reset mid-STOPPING → all outputs return to 0 the next cycle.

Source files
------------

// File: rtl/rx_dma_chan_ctrl_pkg.sv
// Shared types and helpers for the RX DMA per-channel start/stop controller.
package rx_dma_chan_ctrl_pkg;

  localparam logic [1:0] CODE_STOPPED  = 2'b00;
  localparam logic [1:0] CODE_RUNNING  = 2'b01;
  localparam logic [1:0] CODE_STOPPING = 2'b10;

  typedef enum logic [1:0] {
    ST_STOPPED  = CODE_STOPPED,
    ST_RUNNING  = CODE_RUNNING,
    ST_STOPPING = CODE_STOPPING
  } chan_state_e;

  function automatic int chan_idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rx_dma_chan_ctrl_fsm.sv
// One channel: state register, in-flight packet counter, STOP_DONE pulse and,
// with RX_DMA_CHAN_CTRL_TIMEOUT_EN defined, a stop-drain timeout timer.
module rx_dma_chan_ctrl_fsm
  import rx_dma_chan_ctrl_pkg::*;
#(
  parameter int INFLIGHT_WIDTH = 8
`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        cmd_acc,
  input  logic        cmd_start,
  input  logic        acpt,
  input  logic        done,
  output chan_state_e state,
  output logic        chan_en,
  output logic        stop_done,
  output logic        timeout_err,
  output logic        stopping
);

  chan_state_e               state_q, state_d;
  logic [INFLIGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      stop_done_q, stop_done_d;
  logic                      chan_en_q, chan_en_d;

`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic          terr_q, terr_d;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    stop_done_d = 1'b0;

    // Saturate at all-ones on overflow, hold at zero on a spurious DONE.
    if (acpt && !done && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else if (done && !acpt && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      ST_STOPPED: begin
        if (cmd_acc) begin
          if (cmd_start) state_d = ST_RUNNING;
          else           stop_done_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (cmd_acc && !cmd_start) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (cnt_d == '0) begin
          state_d     = ST_STOPPED;
          stop_done_d = 1'b1;
        end
      end
      default: state_d = ST_STOPPED;
    endcase

`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
    terr_d  = terr_q;
    timer_d = (state_q == ST_STOPPING && timer_q != TIMEOUT_VAL) ? timer_q + 1'b1 :
              (state_q == ST_STOPPING) ? timer_q : '0;
    if (cmd_acc && cmd_start) terr_d = 1'b0;
    // Forced stop abandons outstanding packets; late DONEs then hit a zero counter.
    if (state_q == ST_STOPPING && timer_q == TIMEOUT_VAL && cnt_d != '0) begin
      state_d     = ST_STOPPED;
      cnt_d       = '0;
      stop_done_d = 1'b1;
      terr_d      = 1'b1;
    end
`endif

    chan_en_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_STOPPED;
      cnt_q       <= '0;
      stop_done_q <= 1'b0;
      chan_en_q   <= 1'b0;
`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
      timer_q     <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_done_q <= stop_done_d;
      chan_en_q   <= chan_en_d;
`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
      timer_q     <= timer_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign state     = state_q;
  assign chan_en   = chan_en_q;
  assign stop_done = stop_done_q;
  assign stopping  = (state_q == ST_STOPPING);
`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: rtl/rx_dma_chan_ctrl.sv
// RX DMA per-channel start/stop controller top: decodes channel indices and
// instantiates one channel FSM each. Optional macro: RX_DMA_CHAN_CTRL_TIMEOUT_EN.
module rx_dma_chan_ctrl
  import rx_dma_chan_ctrl_pkg::*;
#(
  parameter int CHANNELS       = 16,
  parameter int INFLIGHT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW            = chan_idx_width(CHANNELS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CMD_VLD,
  input  logic [CW-1:0]         CMD_CHAN,
  input  logic                  CMD_START,
  output logic                  CMD_RDY,
  input  logic                  PKT_ACPT_VLD,
  input  logic [CW-1:0]         PKT_ACPT_CHAN,
  input  logic                  PKT_DONE_VLD,
  input  logic [CW-1:0]         PKT_DONE_CHAN,
  output logic [CHANNELS-1:0]   CHAN_EN,
  output logic [2*CHANNELS-1:0] CHAN_STATUS,
  output logic [CHANNELS-1:0]   STOP_DONE,
  output logic [CHANNELS-1:0]   TIMEOUT_ERR
);

  if (CHANNELS < 2 || (CHANNELS & (CHANNELS - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rx_dma_chan_ctrl: CHANNELS must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic [CHANNELS-1:0] stopping_vec;
  logic [CHANNELS-1:0] cmd_sel;
  logic [CHANNELS-1:0] acpt_sel;
  logic [CHANNELS-1:0] done_sel;
  logic                cmd_acc;

  // A STOPPING channel refuses commands so a stop is never re-issued mid-drain.
  assign CMD_RDY = !RESET && !stopping_vec[CMD_CHAN];
  assign cmd_acc = CMD_VLD && CMD_RDY;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      chan_state_e state_w;

      assign cmd_sel[gi]  = cmd_acc && (CMD_CHAN == CW'(gi));
      assign acpt_sel[gi] = PKT_ACPT_VLD && (PKT_ACPT_CHAN == CW'(gi));
      assign done_sel[gi] = PKT_DONE_VLD && (PKT_DONE_CHAN == CW'(gi));

      rx_dma_chan_ctrl_fsm #(
        .INFLIGHT_WIDTH (INFLIGHT_WIDTH)
`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
      ) u_fsm (
        .clk         (CLK),
        .srst        (RESET),
        .cmd_acc     (cmd_sel[gi]),
        .cmd_start   (CMD_START),
        .acpt        (acpt_sel[gi]),
        .done        (done_sel[gi]),
        .state       (state_w),
        .chan_en     (CHAN_EN[gi]),
        .stop_done   (STOP_DONE[gi]),
        .timeout_err (TIMEOUT_ERR[gi]),
        .stopping    (stopping_vec[gi])
      );

      assign CHAN_STATUS[2*gi +: 2] = state_w;
    end
  endgenerate

endmodule

// File: tb/tb_rx_dma_chan_ctrl.sv
// Directed self-checking bench for rx_dma_chan_ctrl (16 channels).
module tb_rx_dma_chan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic [3:0]  cmd_chan;
  logic        cmd_start;
  logic        cmd_rdy;
  logic        acpt_vld;
  logic [3:0]  acpt_chan;
  logic        done_vld;
  logic [3:0]  done_chan;
  logic [15:0] chan_en;
  logic [31:0] chan_status;
  logic [15:0] stop_done;
  logic [15:0] timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_dma_chan_ctrl #(
    .CHANNELS       (16),
    .INFLIGHT_WIDTH (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .CMD_VLD       (cmd_vld),
    .CMD_CHAN      (cmd_chan),
    .CMD_START     (cmd_start),
    .CMD_RDY       (cmd_rdy),
    .PKT_ACPT_VLD  (acpt_vld),
    .PKT_ACPT_CHAN (acpt_chan),
    .PKT_DONE_VLD  (done_vld),
    .PKT_DONE_CHAN (done_chan),
    .CHAN_EN       (chan_en),
    .CHAN_STATUS   (chan_status),
    .STOP_DONE     (stop_done),
    .TIMEOUT_ERR   (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] st(input int ch);
    return chan_status[2*ch +: 2];
  endfunction

  task automatic send_cmd(input int ch, input bit start);
    cmd_vld   = 1'b1;
    cmd_chan  = ch[3:0];
    cmd_start = start;
    #1;
    chk($sformatf("cmd_rdy_ch%0d", ch), {31'd0, cmd_rdy}, 32'd1);
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic pulse_acpt(input int ch);
    acpt_vld  = 1'b1;
    acpt_chan = ch[3:0];
    step();
    acpt_vld = 1'b0;
  endtask

  task automatic pulse_done(input int ch);
    done_vld  = 1'b1;
    done_chan = ch[3:0];
    step();
    done_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_chan = '0; cmd_start = 1'b0;
    acpt_vld = 1'b0; acpt_chan = '0; done_vld = 1'b0; done_chan = '0;
    step();
    step();
    chk("rst_cmd_rdy",  {31'd0, cmd_rdy}, 32'd0);
    chk("rst_chan_en",  {16'd0, chan_en}, 32'd0);
    chk("rst_status",   chan_status, 32'd0);
    chk("rst_stop_done", {16'd0, stop_done}, 32'd0);
    chk("rst_tmo_err",  {16'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    step();

    // Start ch3
    send_cmd(3, 1'b1);
    chk("start3_chan_en", {16'd0, chan_en}, 32'h0008);
    chk("start3_status",  {30'd0, st(3)}, 32'd1);

    // 5 accepts, stop, then 5 DONEs three cycles apart
    for (int i = 0; i < 5; i++) pulse_acpt(3);
    send_cmd(3, 1'b0);
    chk("stop3_status",  {30'd0, st(3)}, 32'd2);
    chk("stop3_chan_en", {16'd0, chan_en}, 32'h0000);
    cmd_chan = 4'd3; #1;
    chk("rdy_ch3_stopping", {31'd0, cmd_rdy}, 32'd0);
    cmd_chan = 4'd4; #1;
    chk("rdy_ch4", {31'd0, cmd_rdy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      pulse_done(3);
      if (i < 4) begin
        chk($sformatf("drain3_%0d_status", i), {30'd0, st(3)}, 32'd2);
        chk($sformatf("drain3_%0d_sd", i), {16'd0, stop_done}, 32'd0);
        step();
        step();
      end else begin
        chk("drain3_done_status", {30'd0, st(3)}, 32'd0);
        chk("drain3_done_sd", {16'd0, stop_done}, 32'h0008);
      end
    end
    cmd_chan = 4'd3; #1;
    chk("rdy_ch3_stopped", {31'd0, cmd_rdy}, 32'd1);
    step();
    chk("drain3_sd_clear", {16'd0, stop_done}, 32'd0);

    // Stop with an accept in the same cycle
    send_cmd(3, 1'b1);
    acpt_vld = 1'b1; acpt_chan = 4'd3;
    send_cmd(3, 1'b0);
    acpt_vld = 1'b0;
    chk("stopacpt_status", {30'd0, st(3)}, 32'd2);
    step(); step(); step();
    chk("stopacpt_hold", {30'd0, st(3)}, 32'd2);
    chk("stopacpt_hold_sd", {16'd0, stop_done}, 32'd0);
    pulse_done(3);
    chk("stopacpt_done_status", {30'd0, st(3)}, 32'd0);
    chk("stopacpt_done_sd", {16'd0, stop_done}, 32'h0008);

    // Simultaneous ACPT/DONE on ch0 with counter 2
    send_cmd(0, 1'b1);
    pulse_acpt(0);
    pulse_acpt(0);
    acpt_vld = 1'b1; acpt_chan = 4'd0;
    done_vld = 1'b1; done_chan = 4'd0;
    step();
    acpt_vld = 1'b0; done_vld = 1'b0;
    send_cmd(0, 1'b0);
    chk("ch0_stopping", {30'd0, st(0)}, 32'd2);
    pulse_done(0);
    chk("ch0_after_1done", {30'd0, st(0)}, 32'd2);
    pulse_done(0);
    chk("ch0_after_2done", {30'd0, st(0)}, 32'd0);
    chk("ch0_sd", {16'd0, stop_done}, 32'h0001);

    // DONE on idle ch1 with counter 0
    pulse_done(1);
    chk("ch1_spurious_status", {30'd0, st(1)}, 32'd0);
    chk("ch1_spurious_sd", {16'd0, stop_done}, 32'd0);
    send_cmd(1, 1'b1);
    send_cmd(1, 1'b0);
    chk("ch1_stopping", {30'd0, st(1)}, 32'd2);
    step();
    chk("ch1_stopped", {30'd0, st(1)}, 32'd0);
    chk("ch1_sd", {16'd0, stop_done}, 32'h0002);

    // ch2 drain completes in the same cycle ch7 gets a stop while STOPPED
    send_cmd(2, 1'b1);
    pulse_acpt(2);
    send_cmd(2, 1'b0);
    chk("ch2_stopping", {30'd0, st(2)}, 32'd2);
    done_vld = 1'b1; done_chan = 4'd2;
    send_cmd(7, 1'b0);
    done_vld = 1'b0;
    chk("multi_sd", {16'd0, stop_done}, 32'h0084);
    chk("multi_status", chan_status, 32'd0);
    step();
    chk("multi_sd_clear", {16'd0, stop_done}, 32'd0);

    // Reset while ch6 is draining
    send_cmd(6, 1'b1);
    chk("ch6_chan_en", {16'd0, chan_en}, 32'h0040);
    pulse_acpt(6);
    send_cmd(6, 1'b0);
    chk("ch6_stopping", {30'd0, st(6)}, 32'd2);
    rst = 1'b1;
    step();
    chk("midrst_status", chan_status, 32'd0);
    chk("midrst_chan_en", {16'd0, chan_en}, 32'd0);
    chk("midrst_sd", {16'd0, stop_done}, 32'd0);
    chk("midrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    rst = 1'b0;
    step();
    chk("postrst_sd", {16'd0, stop_done}, 32'd0);
    send_cmd(6, 1'b1);
    send_cmd(6, 1'b0);
    step();
    chk("ch6_cleared_status", {30'd0, st(6)}, 32'd0);
    chk("ch6_cleared_sd", {16'd0, stop_done}, 32'h0040);

`ifdef RX_DMA_CHAN_CTRL_TIMEOUT_EN
    begin
      int waited;
      send_cmd(5, 1'b1);
      pulse_acpt(5);
      send_cmd(5, 1'b0);
      chk("ch5_stopping", {30'd0, st(5)}, 32'd2);
      waited = 0;
      while (stop_done[5] !== 1'b1 && waited < 40) begin
        step();
        waited++;
      end
      chk("ch5_timeout_seen", {31'd0, stop_done[5]}, 32'd1);
      chk("ch5_timeout_status", {30'd0, st(5)}, 32'd0);
      chk("ch5_timeout_err", {16'd0, timeout_err}, 32'h0020);
      pulse_done(5);
      chk("ch5_late_done_sd", {16'd0, stop_done}, 32'd0);
      send_cmd(5, 1'b1);
      chk("ch5_err_cleared", {16'd0, timeout_err}, 32'd0);
      send_cmd(5, 1'b0);
      step();
      chk("ch5_restop_status", {30'd0, st(5)}, 32'd0);
    end
`else
    chk("tmo_err_tied", {16'd0, timeout_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
